// File: rtl/ioread_mux_db.sv
// ioread_mux_db: multi-channel debounced IO read port.
// Each of NUM_CH raw input buses passes a 2-flop synchroniser and a
// stability debouncer. A registered read port returns the debounced value
// of the lowest-index selected channel to memorio.
// Optional feature macro: IOREAD_CHG_EN adds the per-channel sticky
// ch_changed flags. Without it the port and its logic are absent.
module ioread_mux_db #(
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 4,
    parameter int DB_CYCLES = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ior,
    input  logic [NUM_CH-1:0]        chsel,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [DATA_W-1:0]        ioread_data,
    output logic                     rd_valid,
    output logic                     sel_err
`ifdef IOREAD_CHG_EN
    ,
    output logic [NUM_CH-1:0]        ch_changed
`endif
);

    // Counter only needs to reach DB_CYCLES-1; keep at least one bit so
    // the declaration stays legal when debouncing is disabled.
    localparam int CNT_W = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;

    // Debounced value of every channel, flattened like ch_data.
    logic [NUM_CH*DATA_W-1:0] stable_flat;
`ifdef IOREAD_CHG_EN
    logic [NUM_CH-1:0]        stable_chg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] sync1_reg;
            logic [DATA_W-1:0] sync2_reg;
            logic [DATA_W-1:0] stable_reg;
            logic [DATA_W-1:0] stable_next;

            // Two-flop synchroniser, always present even without debounce.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_reg <= '0;
                    sync2_reg <= '0;
                end else begin
                    sync1_reg <= ch_data[gi*DATA_W +: DATA_W];
                    sync2_reg <= sync1_reg;
                end
            end

            if (DB_CYCLES == 0) begin : g_nodb
                // No debounce: the synchronised value is accepted directly.
                always_comb stable_next = sync2_reg;
            end else begin : g_db
                logic [DATA_W-1:0] cand_reg;
                logic [DATA_W-1:0] cand_next;
                logic [CNT_W-1:0]  cnt_reg;
                logic [CNT_W-1:0]  cnt_next;

                // A new candidate restarts the count; it is accepted once it
                // has been seen on DB_CYCLES+1 consecutive synced samples.
                always_comb begin
                    cand_next   = cand_reg;
                    cnt_next    = cnt_reg;
                    stable_next = stable_reg;
                    if (sync2_reg != cand_reg) begin
                        cand_next = sync2_reg;
                        cnt_next  = '0;
                    end else if (cand_reg != stable_reg) begin
                        if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
                            stable_next = cand_reg;
                            cnt_next    = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end

                // Candidate and counter state; reset drops any pending change.
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        cand_reg <= '0;
                        cnt_reg  <= '0;
                    end else begin
                        cand_reg <= cand_next;
                        cnt_reg  <= cnt_next;
                    end
                end
            end

            // Debounced output register of this channel.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stable_reg <= '0;
                end else begin
                    stable_reg <= stable_next;
                end
            end

            assign stable_flat[gi*DATA_W +: DATA_W] = stable_reg;
`ifdef IOREAD_CHG_EN
            assign stable_chg[gi] = (stable_next != stable_reg);
`endif
        end
    endgenerate

    logic [DATA_W-1:0] sel_data;
    logic              any_sel;
    logic              multi_sel;
`ifdef IOREAD_CHG_EN
    logic [NUM_CH-1:0] win_mask;
`endif

    // Priority select: the lowest set chsel bit wins (scan high to low so
    // the last hit is the lowest index).
    always_comb begin
        sel_data = '0;
        any_sel  = 1'b0;
`ifdef IOREAD_CHG_EN
        win_mask = '0;
`endif
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chsel[i]) begin
                sel_data = stable_flat[i*DATA_W +: DATA_W];
                any_sel  = 1'b1;
`ifdef IOREAD_CHG_EN
                win_mask    = '0;
                win_mask[i] = 1'b1;
`endif
            end
        end
        multi_sel = ((chsel & (chsel - 1'b1)) != '0);
    end

    // Registered read port; data holds whenever no channel is read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ioread_data <= '0;
            rd_valid    <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            rd_valid <= ior & any_sel;
            sel_err  <= ior & multi_sel;
            if (ior && any_sel) begin
                ioread_data <= sel_data;
            end
        end
    end

`ifdef IOREAD_CHG_EN
    // Sticky change flags: a change on the same edge as a clearing read
    // wins so that no event is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_changed <= '0;
        end else begin
            ch_changed <= stable_chg | (ch_changed & ~((ior && any_sel) ? win_mask : '0));
        end
    end
`endif

endmodule

// File: tb/tb_ioread_mux_db.sv
// Testbench for ioread_mux_db: directed scenarios plus randomized traffic,
// all checked against a sample-history reference model.
module tb_ioread_mux_db;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int DB = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              ior;
    logic [NC-1:0]     chsel;
    logic [NC*DW-1:0]  ch_data;
    logic [DW-1:0]     ioread_data;
    logic              rd_valid;
    logic              sel_err;
`ifdef IOREAD_CHG_EN
    logic [NC-1:0]     ch_changed;
`endif

    int checks   = 0;
    int failures = 0;
    bit verbose  = 1'b1;

    ioread_mux_db #(.DATA_W(DW), .NUM_CH(NC), .DB_CYCLES(DB)) dut (
        .clock       (clock),
        .reset       (reset),
        .ior         (ior),
        .chsel       (chsel),
        .ch_data     (ch_data),
        .ioread_data (ioread_data),
        .rd_valid    (rd_valid),
        .sel_err     (sel_err)
`ifdef IOREAD_CHG_EN
        ,
        .ch_changed  (ch_changed)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: last raw sample, window of the last DB+1 synced samples.
    logic [DW-1:0] m_s1     [NC];
    logic [DW-1:0] m_hist   [NC][DB+1];
    logic [DW-1:0] m_stable [NC];
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_err;
    logic [NC-1:0] m_chg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_s1[i]     = '0;
            m_stable[i] = '0;
            for (int j = 0; j <= DB; j++) m_hist[i][j] = '0;
        end
        m_data  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_chg   = '0;
    endtask

    // One clock edge: a value is accepted once the whole window agrees on it.
    task automatic model_step();
        int            win;
        logic          rd;
        logic          all_eq;
        logic [DW-1:0] new_st [NC];
        win = -1;
        for (int i = NC - 1; i >= 0; i--) if (chsel[i]) win = i;
        rd = ior && (win >= 0);
        for (int i = 0; i < NC; i++) begin
            all_eq = 1'b1;
            for (int j = 1; j <= DB; j++) if (m_hist[i][j] != m_hist[i][0]) all_eq = 1'b0;
            new_st[i] = all_eq ? m_hist[i][0] : m_stable[i];
        end
        if (rd) m_data = m_stable[win];
        m_valid = rd;
        m_err   = ior && ($countones(chsel) > 1);
        for (int i = 0; i < NC; i++) begin
            if (new_st[i] != m_stable[i]) m_chg[i] = 1'b1;
            else if (rd && win == i)      m_chg[i] = 1'b0;
            m_stable[i] = new_st[i];
            for (int j = DB; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = m_s1[i];
            m_s1[i]      = ch_data[i*DW +: DW];
        end
    endtask

    task automatic check_outputs();
        check("data", {16'h0, ioread_data}, {16'h0, m_data});
        check("valid", {31'h0, rd_valid}, {31'h0, m_valid});
        check("err", {31'h0, sel_err}, {31'h0, m_err});
`ifdef IOREAD_CHG_EN
        check("chg", {28'h0, ch_changed}, {28'h0, m_chg});
`endif
        if (verbose)
            $display("txn t=%0t ior=%b chsel=%b data=%h valid=%b err=%b",
                     $time, ior, chsel, ioread_data, rd_valid, sel_err);
    endtask

    // Advance one edge, then compare at the following falling edge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    // Assert reset between edges, check the asynchronous clear, release later.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_data", {16'h0, ioread_data}, 32'h0);
        check("rst_valid", {31'h0, rd_valid}, 32'h0);
        check("rst_err", {31'h0, sel_err}, 32'h0);
`ifdef IOREAD_CHG_EN
        check("rst_chg", {28'h0, ch_changed}, 32'h0);
`endif
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] val);
        ch_data[ch*DW +: DW] = val;
    endtask

    logic [DW-1:0] pool [4];

    initial begin
        reset   = 1'b1;
        ior     = 1'b0;
        chsel   = '0;
        ch_data = '0;
        model_reset();
        #1;
        check("init_data", {16'h0, ioread_data}, 32'h0);
        check("init_valid", {31'h0, rd_valid}, 32'h0);
        @(negedge clock);
        #2 reset = 1'b0;

        // Reset mid-run while ch0 is high, then ch0 reaches stable 6 edges later.
        set_ch(0, 16'hFFFF);
        ior = 1'b1; chsel = 4'b0001;
        for (int k = 0; k < 10; k++) cycle();
        check("pre_rst_data", {16'h0, ioread_data}, 32'h0000FFFF);
        async_reset();
        for (int k = 1; k <= 7; k++) begin
            cycle();
            check("t1_data", {16'h0, ioread_data}, (k == 7) ? 32'h0000FFFF : 32'h0);
        end

        // ch1 change observed on the 7th read.
        chsel = 4'b0010;
        cycle();
        set_ch(1, 16'h00A5);
        for (int k = 1; k <= 7; k++) begin
            cycle();
            check("t2_data", {16'h0, ioread_data}, (k == 7) ? 32'h000000A5 : 32'h0);
            check("t2_valid", {31'h0, rd_valid}, 32'h1);
        end

        // Three-cycle glitch on ch2 is filtered out.
        chsel = 4'b0100;
        set_ch(2, 16'h0001);
        for (int k = 0; k < 3; k++) cycle();
        set_ch(2, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("t3_data", {16'h0, ioread_data}, 32'h0);
        end

        // Multi-bit select: lowest channel wins and sel_err pulses.
        ior = 1'b0;
        set_ch(0, 16'h1111);
        set_ch(3, 16'h3333);
        for (int k = 0; k < 8; k++) cycle();
        ior = 1'b1; chsel = 4'b1001;
        cycle();
        check("t4_data", {16'h0, ioread_data}, 32'h00001111);
        check("t4_valid", {31'h0, rd_valid}, 32'h1);
        check("t4_err", {31'h0, sel_err}, 32'h1);
        chsel = 4'b0000;
        cycle();
        check("t4_hold", {16'h0, ioread_data}, 32'h00001111);
        check("t4_nosel", {31'h0, rd_valid}, 32'h0);

        // ior low: chsel ignored, nothing updates.
        ior = 1'b0; chsel = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) set_ch(2, 16'(k * 16'h0101 + 16'h0022));
            cycle();
            check("t5_data", {16'h0, ioread_data}, 32'h00001111);
            check("t5_valid", {31'h0, rd_valid}, 32'h0);
            check("t5_err", {31'h0, sel_err}, 32'h0);
        end

`ifdef IOREAD_CHG_EN
        // Sticky change flag, including change and clearing read on one edge.
        set_ch(3, 16'h0000);
        for (int k = 0; k < 8; k++) cycle();
        ior = 1'b1; chsel = 4'b1000;
        cycle();
        check("t6_clr0", {31'h0, ch_changed[3]}, 32'h0);
        ior = 1'b0;
        set_ch(3, 16'h0F0F);
        for (int k = 0; k < 8; k++) cycle();
        check("t6_set", {31'h0, ch_changed[3]}, 32'h1);
        set_ch(3, 16'h0000);
        for (int k = 1; k <= 5; k++) cycle();
        ior = 1'b1; chsel = 4'b1000;
        cycle();
        check("t6_same_edge", {31'h0, ch_changed[3]}, 32'h1);
        check("t6_data", {16'h0, ioread_data}, 32'h00000F0F);
        cycle();
        check("t6_clr1", {31'h0, ch_changed[3]}, 32'h0);
        check("t6_data2", {16'h0, ioread_data}, 32'h0);
`endif

        // Randomized traffic with occasional asynchronous resets.
        verbose = 1'b0;
        for (int p = 0; p < 4; p++) pool[p] = 16'($urandom);
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, 7) == 0) set_ch(i, pool[$urandom_range(0, 3)]);
            ior   = 1'($urandom_range(0, 1));
            chsel = 4'($urandom);
            if ($urandom_range(0, 299) == 0) async_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
